// File: rtl/dlfloat_pkg.sv
// ---------------------------------------------------------------------------
// dlfloat_pkg
// Shared DLFloat16 definitions for the MAC tile host driver: format widths,
// special encodings, the operand-pair record and the host state encoding.
// ---------------------------------------------------------------------------
package dlfloat_pkg;

  localparam int DLF_W     = 16;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef struct packed {
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
  } dlf_pair_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CLR = 1'b1
  } host_state_t;

endpackage

// File: rtl/dlfloat_pair_fifo.sv
// ---------------------------------------------------------------------------
// dlfloat_pair_fifo
// Synchronous FIFO of operand pairs with a one-edge lookahead view: the head
// and emptiness it will have after the current edge's push/pop. The host uses
// that view to load its registered tile bus at the start of an issue slot.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_din   write request and pair (ignored while full)
//   i_pop           read request (ignored while empty)
//   o_full          all DEPTH entries occupied
//   o_nxt_empty     FIFO will be empty after this edge
//   o_nxt_head      head entry after this edge (valid when !o_nxt_empty)
// ---------------------------------------------------------------------------
module dlfloat_pair_fifo
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  dlf_pair_t i_din,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_nxt_empty,
  output dlf_pair_t o_nxt_head
);

  localparam int AW = $clog2(DEPTH);

  dlf_pair_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_left;
  logic [AW:0]   w_cnt_nxt;
  logic [AW-1:0] w_rd_nxt;

  assign w_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~w_empty;
  assign w_left    = r_cnt - (AW+1)'(w_pop);
  assign w_cnt_nxt = w_left + (AW+1)'(w_push);
  assign w_rd_nxt  = r_rd + AW'(w_pop);

  assign o_nxt_empty = (w_cnt_nxt == '0);
  // When the pop leaves nothing behind, the only possible next head is the
  // pair being written on this same edge.
  assign o_nxt_head  = (w_left == '0) ? i_din : r_mem[w_rd_nxt];

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are meaningful, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/dlfloat_mac_host.sv
// ---------------------------------------------------------------------------
// dlfloat_mac_host
// Host-side driver for the byte-serial DLFloat16 MAC tile. Buffers operand
// pairs, drives A then B onto the tile bus in alternating phases, rebuilds
// 16-bit accumulator words from the tile's low/high byte stream and runs an
// accumulator-clear sequence by pulsing the tile reset.
// Ports:
//   clk, rst_n            shared clock, asynchronous active-low reset
//   op_valid/op_ready     operand pair handshake, op_a/op_b operands
//   clr_req, clr_busy     clear request pulse and clear-in-progress flag
//   bus_out               registered tile input bus {uio_in,ui_in}
//   dut_rst_n             tile reset (low during host reset and clear)
//   byte_in               tile output byte (lo in ph1, hi in following ph0)
//   res_valid, res_data   one-cycle result pulse and held {hi,lo} word
// ---------------------------------------------------------------------------
module dlfloat_mac_host
  import dlfloat_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LAT_PAIRS  = 2,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DLF_W-1:0] op_a,
  input  logic [DLF_W-1:0] op_b,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic [DLF_W-1:0] bus_out,
  output logic             dut_rst_n,
  input  logic [7:0]       byte_in,
  output logic             res_valid,
  output logic [DLF_W-1:0] res_data
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  host_state_t        r_state;
  logic [CW-1:0]      r_clr_cnt;
  logic               r_clr_active;
  logic               r_ph;
  logic               r_issuing;
  logic [DLF_W-1:0]   r_bus_out;
  logic [7:0]         r_lo;
  logic               r_lo_seen;
  logic [LAT_PAIRS-1:0] r_tag;
  logic               r_res_valid;
  logic [DLF_W-1:0]   r_res_data;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_nxt_empty;
  dlf_pair_t          w_nxt_head;
  dlf_pair_t          w_din;
  logic [LAT_PAIRS:0] w_tag_sh;

  assign op_ready  = ~w_full & (r_state == ST_RUN);
  assign w_push    = op_valid & op_ready;
  // A pair leaves the FIFO only when its B half completes; a clear landing on
  // that cycle aborts it so it is sent again afterwards.
  assign w_pop     = (r_state == ST_RUN) & r_ph & r_issuing & ~clr_req;
  assign w_din     = '{a: op_a, b: op_b};
  assign w_tag_sh  = {r_tag, r_issuing};

  assign clr_busy  = r_clr_active;
  assign dut_rst_n = rst_n & ~r_clr_active;
  assign bus_out   = r_bus_out;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  dlfloat_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_din       (w_din),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_nxt_empty (w_nxt_empty),
    .o_nxt_head  (w_nxt_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_clr_cnt    <= '0;
      r_clr_active <= 1'b0;
      r_ph         <= 1'b0;
      r_issuing    <= 1'b0;
      r_bus_out    <= DLF_ZERO;
      r_lo         <= '0;
      r_lo_seen    <= 1'b0;
      r_tag        <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= DLF_ZERO;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (clr_req) begin
            r_state      <= ST_CLR;
            r_clr_active <= 1'b1;
            r_clr_cnt    <= '0;
            r_ph         <= 1'b0;
            r_issuing    <= 1'b0;
            r_bus_out    <= DLF_ZERO;
            r_lo_seen    <= 1'b0;
            r_tag        <= '0;
          end else begin
            r_ph <= ~r_ph;
            if (r_ph) begin
              // Closing ph1: capture the low byte and open the next issue slot.
              r_lo      <= byte_in;
              r_lo_seen <= 1'b1;
              r_issuing <= ~w_nxt_empty;
              r_bus_out <= w_nxt_empty ? DLF_ZERO : w_nxt_head.a;
            end else begin
              // Closing ph0: head cannot move here, so the lookahead head is
              // the pair currently in issue.
              r_bus_out <= r_issuing ? w_nxt_head.b : DLF_ZERO;
              if (r_lo_seen) begin
                r_tag <= w_tag_sh[LAT_PAIRS-1:0];
                if (r_tag[LAT_PAIRS-1]) begin
                  r_res_valid <= 1'b1;
                  r_res_data  <= {byte_in, r_lo};
                end
              end
            end
          end
        end
        ST_CLR: begin
          if (r_clr_cnt == CW'(CLR_CYCLES - 1)) begin
            r_state      <= ST_RUN;
            r_clr_active <= 1'b0;
            r_issuing    <= ~w_nxt_empty;
            r_bus_out    <= w_nxt_empty ? DLF_ZERO : w_nxt_head.a;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_host.sv
// ---------------------------------------------------------------------------
// tb_dlfloat_mac_host
// Directed bench for dlfloat_mac_host. Cycle numbers in comments count rising
// edges after reset release; cycle k is the interval after edge k, ph = k%2.
// ---------------------------------------------------------------------------
module tb_dlfloat_mac_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        clr_req;
  logic        clr_busy;
  logic [15:0] bus_out;
  logic        dut_rst_n;
  logic [7:0]  byte_in;
  logic        res_valid;
  logic [15:0] res_data;

  int n_checks = 0;
  int n_errors = 0;

  dlfloat_mac_host #(.FIFO_DEPTH(4), .LAT_PAIRS(2), .CLR_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .bus_out   (bus_out),
    .dut_rst_n (dut_rst_n),
    .byte_in   (byte_in),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    clr_req  = 1'b0;
    byte_in  = 8'hA5;

    repeat (3) tick();
    check("rst_dut_rst_n", dut_rst_n, 0);
    check("rst_bus", bus_out, 16'h0000);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_clr_busy", clr_busy, 0);

    // cycle 0 (ph0)
    rst_n = 1'b1;
    #1;
    check("rel_dut_rst_n", dut_rst_n, 1);
    check("rel_op_ready", op_ready, 1);
    push(16'h3E00, 16'h4000);
    tick(); // c1: pair pushed, this ph1 still a bubble
    op_valid = 1'b0;
    check("t1_c1_bus", bus_out, 16'h0000);
    tick(); // c2
    check("t1_bus_a", bus_out, 16'h3E00);
    tick(); // c3
    check("t1_bus_b", bus_out, 16'h4000);
    check("t3_c3_nores", res_valid, 0);
    tick(); // c4: popped, FIFO empty
    check("t3_bubble_c4", bus_out, 16'h0000);
    tick(); // c5
    byte_in = 8'h34;
    check("t3_c5_nores", res_valid, 0);
    check("t3_bubble_c5", bus_out, 16'h0000);
    tick(); // c6
    byte_in = 8'h12;
    check("t3_bubble_c6", bus_out, 16'h0000);
    tick(); // c7
    byte_in = 8'hA5;
    check("t2_res_valid", res_valid, 1);
    check("t2_res_data", res_data, 16'h1234);
    tick(); // c8
    check("t2_pulse_end", res_valid, 0);
    check("t2_data_hold", res_data, 16'h1234);

    // Fill the FIFO: q0..q4 pushed at edges 9..13
    push(16'h3E00, 16'h3E01);
    tick(); // c9
    check("t3_c9_nores", res_valid, 0);
    push(16'h3F00, 16'h3F01);
    tick(); // c10
    check("t4_q0_a", bus_out, 16'h3E00);
    push(16'h4000, 16'h4001);
    tick(); // c11
    push(16'h4100, 16'h4101);
    tick(); // c12
    check("t4_ready_c12", op_ready, 1);
    check("t4_q1_a", bus_out, 16'h3F00);
    push(16'hFFFF, 16'h4201);
    tick(); // c13: full, a pop is due this edge but the push is still refused
    check("t4_full_ready", op_ready, 0);
    check("t4_q1_b", bus_out, 16'h3F01);
    push(16'h5555, 16'h6666);
    tick(); // c14
    op_valid = 1'b0;
    check("t4_ready_after_pop", op_ready, 1);
    check("t4_q2_a", bus_out, 16'h4000);
    tick(); // c15
    byte_in = 8'h56;
    tick(); // c16
    byte_in = 8'h78;
    check("t4_q3_a", bus_out, 16'h4100);
    tick(); // c17: clear requested while q3 B is on the bus
    byte_in = 8'hA5;
    check("t4_q1_res_valid", res_valid, 1);
    check("t4_q1_res_data", res_data, 16'h7856);
    check("t5_q3_b", bus_out, 16'h4101);
    clr_req = 1'b1;
    tick(); // c18
    clr_req = 1'b0;
    check("t5_busy_c18", clr_busy, 1);
    check("t5_tile_rst_c18", dut_rst_n, 0);
    check("t5_bus_c18", bus_out, 16'h0000);
    check("t5_ready_c18", op_ready, 0);
    tick(); // c19
    check("t5_busy_c19", clr_busy, 1);
    check("t5_tile_rst_c19", dut_rst_n, 0);
    check("t5_lost_res", res_valid, 0);
    tick(); // c20
    check("t5_busy_done", clr_busy, 0);
    check("t5_tile_rst_done", dut_rst_n, 1);
    check("t5_reissue_a", bus_out, 16'h4100);
    tick(); // c21
    check("t5_reissue_b", bus_out, 16'h4101);
    tick(); // c22
    check("t5_q4_a_nan", bus_out, 16'hFFFF);
    tick(); // c23
    tick(); // c24: refused pair never shows up
    check("t4_refused_absent", bus_out, 16'h0000);
    tick(); // c25
    byte_in = 8'hFF;
    check("t5_hi_discarded", res_valid, 0);
    tick(); // c26
    tick(); // c27
    byte_in = 8'hA5;
    check("t5_q4_res_valid", res_valid, 1);
    check("t5_q4_res_nan", res_data, 16'hFFFF);
    push(16'h1357, 16'h2468);
    tick(); // c28
    op_valid = 1'b0;
    check("t6_s_a", bus_out, 16'h1357);
    tick(); // c29: asynchronous reset mid-issue
    rst_n = 1'b0;
    #1;
    check("t6_bus", bus_out, 16'h0000);
    check("t6_res_valid", res_valid, 0);
    check("t6_res_data", res_data, 16'h0000);
    check("t6_dut_rst_n", dut_rst_n, 0);
    check("t6_clr_busy", clr_busy, 0);
    repeat (2) tick();
    rst_n = 1'b1; // new cycle 0
    tick(); // c1
    tick(); // c2
    check("t6_empty_c2", bus_out, 16'h0000);
    tick(); // c3
    check("t6_empty_c3", bus_out, 16'h0000);
    check("t6_ready", op_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
